// File: rtl/imm_enc_pkg.sv
// Shared types and constants for the RV64I immediate encoder.
// Formats, major opcodes and sequencer states.
package imm_enc_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_t;

    typedef enum logic {
        IDLE  = 1'b0,
        EMIT2 = 1'b1
    } state_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;

    localparam logic signed [63:0] LI_MIN = -64'sd2147483648;
    localparam logic signed [63:0] LI_MAX = 64'sh0000_0000_7FFF_F7FF;

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response handshake bundle of the immediate encoder.
// master drives requests and consumes words; slave is the encoder.
interface imm_encoder_if;

    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic        err;

    modport master (
        output in_valid, fmt, opcode, funct3, funct7,
        output rd, rs1, rs2, imm, out_ready,
        input  in_ready, out_valid, instr, err
    );

    modport slave (
        input  in_valid, fmt, opcode, funct3, funct7,
        input  rd, rs1, rs2, imm, out_ready,
        output in_ready, out_valid, instr, err
    );

endinterface

// File: rtl/imm_pack.sv
// Combinational RV instruction field packer and immediate range check.
// range_ok is low for illegal formats as well.
module imm_pack
    import imm_enc_pkg::*;
(
    input  logic [2:0]  fmt,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [63:0] imm,
    output logic [31:0] word,
    output logic        range_ok
);

    logic is_r, is_i, is_s, is_b, is_u, is_j;
    logic fit12, fit13, fit21, fit32;

    assign is_r = (fmt == FMT_R);
    assign is_i = (fmt == FMT_I);
    assign is_s = (fmt == FMT_S);
    assign is_b = (fmt == FMT_B);
    assign is_u = (fmt == FMT_U);
    assign is_j = (fmt == FMT_J);

    // A value fits N signed bits when all bits above N-1 copy the sign.
    assign fit12 = (imm[63:11] == '0) || (imm[63:11] == '1);
    assign fit13 = (imm[63:12] == '0) || (imm[63:12] == '1);
    assign fit21 = (imm[63:20] == '0) || (imm[63:20] == '1);
    assign fit32 = (imm[63:31] == '0) || (imm[63:31] == '1);

    always_comb begin
        word     = '0;
        range_ok = 1'b0;
        unique case (1'b1)
            is_r: begin
                word = {funct7, rs2, rs1, funct3, rd, opcode};
                range_ok = 1'b1;
            end
            is_i: begin
                word = {imm[11:0], rs1, funct3, rd, opcode};
                range_ok = fit12;
            end
            is_s: begin
                word = {imm[11:5], rs2, rs1, funct3,
                        imm[4:0], opcode};
                range_ok = fit12;
            end
            is_b: begin
                word = {imm[12], imm[10:5], rs2, rs1, funct3,
                        imm[4:1], imm[11], opcode};
                range_ok = fit13 && !imm[0];
            end
            is_u: begin
                word = {imm[31:12], rd, opcode};
                range_ok = fit32 && (imm[11:0] == '0);
            end
            is_j: begin
                word = {imm[20], imm[10:1], imm[11],
                        imm[19:12], rd, opcode};
                range_ok = fit21 && !imm[0];
            end
            default: begin
                word     = '0;
                range_ok = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Immediate encoder top: handshake, li expansion sequencer,
// single-entry output register and saturating word counter.
module imm_encoder
    import imm_enc_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic             clk,
    input  logic             reset,
    imm_encoder_if.slave     bus,
    output logic [CNT_W-1:0] word_count
);

    state_t           state, state_nxt;
    logic             vld_q, vld_nxt;
    logic             err_q, err_nxt;
    logic [31:0]      instr_q, instr_nxt;
    logic [11:0]      lo_q, lo_nxt;
    logic [4:0]       rd_q, rd_nxt;
    logic [CNT_W-1:0] cnt_q, cnt_nxt;

    logic [31:0] word;
    logic        range_ok;
    logic        accept, take;
    logic        li_cand, li_fit, do_exp;
    logic [19:0] hi;

    imm_pack u_pack (
        .fmt      (bus.fmt),
        .opcode   (bus.opcode),
        .funct3   (bus.funct3),
        .funct7   (bus.funct7),
        .rd       (bus.rd),
        .rs1      (bus.rs1),
        .rs2      (bus.rs2),
        .imm      (bus.imm),
        .word     (word),
        .range_ok (range_ok)
    );

    assign bus.in_ready  = (state == IDLE) && (!vld_q || bus.out_ready);
    assign bus.out_valid = vld_q;
    assign bus.instr     = instr_q;
    assign bus.err       = err_q;
    assign word_count    = cnt_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign take   = vld_q && bus.out_ready;

    assign li_cand = (bus.fmt == FMT_I) && (bus.opcode == OP_IMM)
                  && (bus.funct3 == 3'b000) && (bus.rs1 == 5'd0);
    assign li_fit  = ($signed(bus.imm) >= LI_MIN)
                  && ($signed(bus.imm) <= LI_MAX);
    assign do_exp  = li_cand && !range_ok && li_fit;

    // Rounds hi up when the low 12 bits sign-extend negative in ADDI.
    assign hi = bus.imm[31:12] + {19'd0, bus.imm[11]};

    always_comb begin
        state_nxt = state;
        vld_nxt   = vld_q;
        err_nxt   = err_q;
        instr_nxt = instr_q;
        lo_nxt    = lo_q;
        rd_nxt    = rd_q;
        cnt_nxt   = cnt_q;
        if (take && !err_q && !(&cnt_q))
            cnt_nxt = cnt_q + 1'b1;
        if (take)
            vld_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    vld_nxt = 1'b1;
                    err_nxt = 1'b0;
                    if (do_exp) begin
                        instr_nxt = {hi, bus.rd, OP_LUI};
                        lo_nxt    = bus.imm[11:0];
                        rd_nxt    = bus.rd;
                        state_nxt = EMIT2;
                    end else if (range_ok) begin
                        instr_nxt = word;
                    end else begin
                        instr_nxt = '0;
                        err_nxt   = 1'b1;
                    end
                end
            end
            EMIT2: begin
                if (bus.out_ready) begin
                    vld_nxt   = 1'b1;
                    err_nxt   = 1'b0;
                    instr_nxt = {lo_q, rd_q, 3'b000, rd_q, OP_IMM};
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            instr_q <= '0;
            lo_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            vld_q   <= vld_nxt;
            err_q   <= err_nxt;
            instr_q <= instr_nxt;
            lo_q    <= lo_nxt;
            rd_q    <= rd_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed self-checking bench for imm_encoder.
// Small CNT_W so the counter saturates within the vector set.
module tb_imm_encoder;
    import imm_enc_pkg::*;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [CW-1:0] word_count;
    int            checks = 0;
    int            fails = 0;
    int            exp_cnt = 0;

    imm_encoder_if bus ();

    imm_encoder #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [2:0] f,
                           input logic [6:0] op,
                           input logic [2:0] f3,
                           input logic [6:0] f7,
                           input logic [4:0] d,
                           input logic [4:0] s1,
                           input logic [4:0] s2,
                           input logic [63:0] im);
        bus.fmt      = f;
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7   = f7;
        bus.rd       = d;
        bus.rs1      = s1;
        bus.rs2      = s2;
        bus.imm      = im;
        bus.in_valid = 1'b1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) check("in_ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic send(input logic [2:0] f,
                        input logic [6:0] op,
                        input logic [2:0] f3,
                        input logic [6:0] f7,
                        input logic [4:0] d,
                        input logic [4:0] s1,
                        input logic [4:0] s2,
                        input logic [63:0] im);
        set_req(f, op, f3, f7, d, s1, s2, im);
        wait_ready();
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic take(input string tag,
                        input logic [31:0] ei,
                        input logic ee);
        check({tag, "_vld"}, {63'd0, bus.out_valid}, 64'd1);
        check({tag, "_instr"}, {32'd0, bus.instr}, {32'd0, ei});
        check({tag, "_err"}, {63'd0, bus.err}, {63'd0, ee});
        tick();
        if (!ee && exp_cnt < CMAX) exp_cnt++;
        check({tag, "_cnt"}, {60'd0, word_count}, 64'(exp_cnt));
    endtask

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.fmt       = '0;
        bus.opcode    = '0;
        bus.funct3    = '0;
        bus.funct7    = '0;
        bus.rd        = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        bus.imm       = '0;
        #1;
        check("rst_vld", {63'd0, bus.out_valid}, 64'd0);
        check("rst_instr", {32'd0, bus.instr}, 64'd0);
        check("rst_err", {63'd0, bus.err}, 64'd0);
        check("rst_cnt", {60'd0, word_count}, 64'd0);
        check("rst_inrdy", {63'd0, bus.in_ready}, 64'd1);
        tick();
        reset = 1'b1;
        tick();

        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, -64'sd1);
        take("addi_m1", 32'hFFF00293, 1'b0);
        check("addi_m1_idle", {63'd0, bus.out_valid}, 64'd0);

        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0,
             64'h12345678);
        check("li_inrdy_lo", {63'd0, bus.in_ready}, 64'd0);
        take("li_lui", 32'h123452B7, 1'b0);
        check("li_inrdy_hi", {63'd0, bus.in_ready}, 64'd1);
        take("li_addi", 32'h67828293, 1'b0);

        send(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, -64'sd4);
        take("beq_m4", 32'hFE208EE3, 1'b0);
        send(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'd3);
        take("beq_odd", 32'h0, 1'b1);
        send(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'd4094);
        take("beq_max", 32'h7E208FE3, 1'b0);
        send(FMT_B, OP_BRANCH, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 64'd4096);
        take("beq_ovf", 32'h0, 1'b1);

        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'd2047);
        take("i_2047", 32'h7FF00293, 1'b0);
        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, -64'sd2048);
        take("i_m2048", 32'h80000293, 1'b0);
        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'd2048);
        take("li2048_lui", 32'h000012B7, 1'b0);
        take("li2048_addi", 32'h80028293, 1'b0);
        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0,
             64'h7FFFF800);
        take("li_ovf", 32'h0, 1'b1);
        check("li_ovf_single", {63'd0, bus.out_valid}, 64'd0);

        send(FMT_S, OP_STORE, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, -64'sd8);
        take("sw_m8", 32'hFE20AC23, 1'b0);
        send(FMT_U, OP_LUI, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
             64'h12345000);
        take("lui", 32'h123450B7, 1'b0);
        send(FMT_U, OP_LUI, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0,
             64'h12345001);
        take("lui_low", 32'h0, 1'b1);
        send(FMT_J, OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd8);
        take("jal_8", 32'h008000EF, 1'b0);
        send(FMT_J, OP_JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd9);
        take("jal_odd", 32'h0, 1'b1);
        send(FMT_R, 7'b0110011, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 64'd5);
        take("add", 32'h002081B3, 1'b0);
        send(3'd6, OP_IMM, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 64'd1);
        take("fmt6", 32'h0, 1'b1);

        set_req(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 64'd1);
        wait_ready();
        tick();
        set_req(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 64'd2);
        check("b2b_a", {32'd0, bus.instr}, 64'h00100093);
        check("b2b_a_rdy", {63'd0, bus.in_ready}, 64'd1);
        tick();
        set_req(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd3, 5'd0, 5'd0, 64'd3);
        check("b2b_b", {32'd0, bus.instr}, 64'h00200113);
        tick();
        bus.in_valid = 1'b0;
        check("b2b_c", {32'd0, bus.instr}, 64'h00300193);
        tick();
        exp_cnt = (exp_cnt + 3 > CMAX) ? CMAX : exp_cnt + 3;
        check("cnt_sat", {60'd0, word_count}, 64'(exp_cnt));

        bus.out_ready = 1'b0;
        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0,
             64'h12345678);
        set_req(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 64'd7);
        for (int i = 0; i < 3; i++) begin
            check("bp_lui", {32'd0, bus.instr}, 64'h123452B7);
            check("bp_vld", {63'd0, bus.out_valid}, 64'd1);
            check("bp_inrdy", {63'd0, bus.in_ready}, 64'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        check("bp_emit2_rdy", {63'd0, bus.in_ready}, 64'd0);
        take("bp_lui_go", 32'h123452B7, 1'b0);
        take("bp_addi", 32'h67828293, 1'b0);
        bus.in_valid = 1'b0;
        take("bp_next", 32'h00700313, 1'b0);
        check("bp_idle", {63'd0, bus.out_valid}, 64'd0);

        bus.out_ready = 1'b0;
        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0,
             64'h12345678);
        #2;
        reset = 1'b0;
        #1;
        exp_cnt = 0;
        check("mid_rst_vld", {63'd0, bus.out_valid}, 64'd0);
        check("mid_rst_cnt", {60'd0, word_count}, 64'd0);
        check("mid_rst_instr", {32'd0, bus.instr}, 64'd0);
        tick();
        reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("no_addi", {63'd0, bus.out_valid}, 64'd0);
        end
        send(FMT_I, OP_IMM, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, -64'sd1);
        take("post_rst", 32'hFFF00293, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
